picomips_top: RTL and testbench



---
 rtl/picomips_top.sv | 172 +++++++++++++++++
 tb/tb_picomips_top.sv | 137 +++++++++++++
 2 files changed

// File: rtl/picomips_top.sv
// picoMIPS affine-transform processor: switch handshake front end driving a
// tiny programmable core (program ROM, register file, ALU with 8x8 multiplier).

package picomips_pkg;
  typedef enum logic [2:0] {
    OP_HALT = 3'd0,
    OP_LDI  = 3'd1,
    OP_ADD  = 3'd2,
    OP_ADDI = 3'd3,
    OP_MULI = 3'd4
  } opcode_e;

  // MULI rd, rs, imm : rd = (rs * imm) >> 7, i.e. Q1.7 coefficient multiply
  typedef struct packed {
    opcode_e    op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] imm;
  } instr_t;

  localparam logic [2:0] R_X  = 3'd1;
  localparam logic [2:0] R_Y  = 3'd2;
  localparam logic [2:0] R_XP = 3'd3;
  localparam logic [2:0] R_T  = 3'd4;
  localparam logic [2:0] R_YP = 3'd5;
  localparam logic [2:0] R_U  = 3'd6;
endpackage

module picomips_prog_mem
  import picomips_pkg::*;
#(
  parameter int PROG_ADDR_WIDTH = 5
) (
  input  logic [PROG_ADDR_WIDTH-1:0] addr,
  output instr_t                     instr
);
  instr_t memory [2**PROG_ADDR_WIDTH];

  // NOTE: every entry gets a default before the program overlays it, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 2**PROG_ADDR_WIDTH; i++) begin
      memory[i] = '{op: OP_HALT, rd: 3'd0, rs: 3'd0, imm: 8'd0};
    end
    memory[0] = '{op: OP_MULI, rd: R_XP, rs: R_X, imm: 8'h40};  //  0.5   * x
    memory[1] = '{op: OP_MULI, rd: R_T,  rs: R_Y, imm: 8'h90};  // -0.875 * y
    memory[2] = '{op: OP_ADD,  rd: R_XP, rs: R_T, imm: 8'h00};
    memory[3] = '{op: OP_ADDI, rd: R_XP, rs: 3'd0, imm: 8'h05};
    memory[4] = '{op: OP_MULI, rd: R_YP, rs: R_X, imm: 8'h90};  // -0.875 * x
    memory[5] = '{op: OP_MULI, rd: R_U,  rs: R_Y, imm: 8'h60};  //  0.75  * y
    memory[6] = '{op: OP_ADD,  rd: R_YP, rs: R_U, imm: 8'h00};
    memory[7] = '{op: OP_ADDI, rd: R_YP, rs: 3'd0, imm: 8'h0C};
    memory[8] = '{op: OP_HALT, rd: 3'd0, rs: 3'd0, imm: 8'h00};
  end

  assign instr = memory[addr];
endmodule

module picomips_top
  import picomips_pkg::*;
#(
  parameter int N               = 8,
  parameter int SW_WIDTH        = 10,
  parameter int PROG_ADDR_WIDTH = 5
) (
  input  logic                clk,
  input  logic [SW_WIDTH-1:0] SW,
  output logic [N-1:0]        LED
);
  typedef enum logic [2:0] {WAIT_X, REL_X, WAIT_Y, COMPUTE, SHOW_X, SHOW_Y} state_e;

  logic                       rst;
  logic [N:0]                 sw_meta, sw_sync;
  logic                       hs_prev, hs_rise, hs_fall;
  state_e                     state, state_n;
  logic                       cap_x, cap_y, load_y, done;
  logic [PROG_ADDR_WIDTH-1:0] pc;
  instr_t                     instr;
  logic [N-1:0]               rf [8];
  logic [N-1:0]               alu_res;
  logic                       alu_we;
  logic signed [2*N-1:0]      prod;
  logic                       unused_prod;

  assign rst = SW[SW_WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
      hs_prev <= 1'b0;
    end else begin
      sw_meta <= SW[N:0];
      sw_sync <= sw_meta;
      hs_prev <= sw_sync[N];
    end
  end

  assign hs_rise = sw_sync[N] & ~hs_prev;
  assign hs_fall = ~sw_sync[N] & hs_prev;

  picomips_prog_mem #(.PROG_ADDR_WIDTH(PROG_ADDR_WIDTH)) mem0 (
    .addr  (pc),
    .instr (instr)
  );

  assign done = (state == COMPUTE) && (instr.op == OP_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_X;
    else     state <= state_n;
  end

  // A rise in SHOW_X can only follow a fall, so a switch still high on entry is waited out.
  always_comb begin
    state_n = state;
    cap_x   = 1'b0;
    cap_y   = 1'b0;
    load_y  = 1'b0;
    unique case (state)
      WAIT_X:  if (hs_rise) begin cap_x = 1'b1; state_n = REL_X; end
      REL_X:   if (hs_fall) state_n = WAIT_Y;
      WAIT_Y:  if (hs_rise) begin cap_y = 1'b1; state_n = COMPUTE; end
      COMPUTE: if (done) state_n = SHOW_X;
      SHOW_X:  if (hs_rise) begin load_y = 1'b1; state_n = SHOW_Y; end
      SHOW_Y:  if (hs_fall) state_n = WAIT_X;
      default: state_n = WAIT_X;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             pc <= '0;
    else if (cap_y)                      pc <= '0;
    else if (state == COMPUTE && !done)  pc <= pc + 1'b1;
  end

  assign prod        = $signed(rf[instr.rs]) * $signed(instr.imm);
  assign unused_prod = ^{prod[2*N-1], prod[N-2:0]};

  always_comb begin
    alu_res = '0;
    alu_we  = 1'b0;
    if (state == COMPUTE) begin
      case (instr.op)
        OP_LDI:  begin alu_res = instr.imm;                  alu_we = 1'b1; end
        OP_ADD:  begin alu_res = rf[instr.rd] + rf[instr.rs]; alu_we = 1'b1; end
        OP_ADDI: begin alu_res = rf[instr.rd] + instr.imm;    alu_we = 1'b1; end
        OP_MULI: begin alu_res = prod[2*N-2:N-1];             alu_we = 1'b1; end
        default: ;
      endcase
    end
  end

  // NOTE: the register file is small and must read as zero after reset, so it is reset explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (cap_x) begin
      rf[R_X] <= sw_sync[N-1:0];
    end else if (cap_y) begin
      rf[R_Y] <= sw_sync[N-1:0];
    end else if (alu_we) begin
      rf[instr.rd] <= alu_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         LED <= '0;
    else if (done)   LED <= rf[R_XP];
    else if (load_y) LED <= rf[R_YP];
  end
endmodule

// File: tb/tb_picomips_top.sv
// Self-checking bench for picomips_top: directed vector table, reset-abort and
// switch-held-high sequences, then a random sample checked against a model.

module tb_picomips_top;
  logic       clk = 1'b0;
  logic [9:0] SW;
  logic [7:0] LED;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  picomips_top dut (
    .clk (clk),
    .SW  (SW),
    .LED (LED)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] exp_x;
    logic [7:0] exp_y;
    string      name;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic phase(input logic [7:0] d, input int high_cycles);
    SW[7:0] = d;
    SW[8]   = 1'b1;
    cycles(high_cycles);
    SW[8]   = 1'b0;
    cycles(6);
  endtask

  function automatic logic [7:0] tq(input int p);
    int q;
    q = p >>> 7;
    return q[7:0];
  endfunction

  function automatic logic [7:0] model_x(input logic signed [7:0] x, input logic signed [7:0] y);
    return tq(64 * int'(x)) + tq(-112 * int'(y)) + 8'd5;
  endfunction

  function automatic logic [7:0] model_y(input logic signed [7:0] x, input logic signed [7:0] y);
    return tq(-112 * int'(x)) + tq(96 * int'(y)) + 8'd12;
  endfunction

  // Full transaction; the x' check lands 32 cycles after the raw y rise.
  task automatic transact(input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] ex, input logic [7:0] ey, input string name);
    phase(x, 6);
    phase(y, 6);
    cycles(20);
    check({name, " x'"}, LED, ex);
    SW[7:0] = ~x;
    cycles(3);
    check({name, " x' hold"}, LED, ex);
    SW[8] = 1'b1;
    cycles(5);
    check({name, " y'"}, LED, ey);
    SW[8] = 1'b0;
    cycles(6);
    check({name, " y' hold"}, LED, ey);
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h00, 8'h05, 8'h0C, "zero"};
    vecs[1] = '{8'h7F, 8'h7F, 8'hD4, 8'hFB, "max"};
    vecs[2] = '{8'h80, 8'h80, 8'h35, 8'h1C, "min"};
    vecs[3] = '{8'h80, 8'h7F, 8'h55, 8'hDB, "wrap"};
    vecs[4] = '{8'h01, 8'hFF, 8'h05, 8'h0A, "trunc"};
    vecs[5] = '{8'h0A, 8'hEC, 8'h1B, 8'hF4, "mixed"};

    SW = 10'h200;
    cycles(3);
    SW[9] = 1'b0;
    cycles(2);
    check("reset LED", LED, 8'h00);

    for (int i = 0; i < 6; i++) begin
      transact(vecs[i].x, vecs[i].y, vecs[i].exp_x, vecs[i].exp_y, vecs[i].name);
    end

    // Abort after x capture: LED clears and the next pair starts from WAIT_X.
    phase(8'h7F, 6);
    SW[9] = 1'b1;
    #12;
    SW[9] = 1'b0;
    #1;
    check("abort LED", LED, 8'h00);
    cycles(4);
    check("abort LED idle", LED, 8'h00);
    transact(8'h00, 8'h00, 8'h05, 8'h0C, "after abort");

    // y switch still high when SHOW_X is entered: must not skip to y'.
    phase(8'h7F, 6);
    SW[7:0] = 8'h7F;
    SW[8]   = 1'b1;
    cycles(30);
    check("held x'", LED, 8'hD4);
    SW[8] = 1'b0;
    cycles(6);
    check("held x' after release", LED, 8'hD4);
    SW[8] = 1'b1;
    cycles(5);
    check("held y'", LED, 8'hFB);
    SW[8] = 1'b0;
    cycles(6);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] rx, ry;
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      transact(rx, ry, model_x(rx, ry), model_y(rx, ry), $sformatf("rand x=%0d y=%0d", $signed(rx), $signed(ry)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
